lcd_image_sequencer: RTL and testbench

- Parametrised pixel-stream generator for the SPI LCD path. It sits between the LCD init sequencer and the LCD SPI writer, and reads 1-bit-per-pixel images from a multi-image ROM.
- Centres an IMG_W x IMG_H image on an SCR_W x SCR_H screen and emits one RGB332 pixel word per write handshake.
- Cycles through NUM_IMAGES images, switching only at frame boundaries (tear-free), with pause/next/prev controls.
- Accounts for ROM read latency and uses programmable foreground/background/border colours.

---
 rtl/lcd_pkg.sv | 20 ++
 rtl/lcd_image_switch_ctrl.sv | 74 +++++++
 rtl/lcd_image_sequencer.sv | 166 ++++++++++++++++
 tb/tb_lcd_image_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD pixel path.
package lcd_pkg;

    localparam logic [7:0] BLACK   = 8'h00;
    localparam logic [7:0] WHITE   = 8'hFF;
    localparam logic       DC_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } seq_state_t;

    // Width of a counter/index that must hold at least one bit even for n == 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_image_switch_ctrl.sv
// Image selection: auto-advance timer, next/prev request flags and the image id,
// which only moves on a frame boundary.
module lcd_image_switch_ctrl
    import lcd_pkg::*;
#(
    parameter int NUM_IMAGES    = 5,
    parameter int SWITCH_CYCLES = 12500000,
    parameter int ID_W          = clog2_min1(NUM_IMAGES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            pause,
    input  logic            next_req,
    input  logic            prev_req,
    input  logic            frame_end,
    output logic [ID_W-1:0] image_id
);

    localparam int              TW         = clog2_min1(SWITCH_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(SWITCH_CYCLES - 1);
    localparam logic [ID_W-1:0] IMG_LAST   = ID_W'(NUM_IMAGES - 1);

    logic [TW-1:0]   timer_q, timer_d;
    logic            pending_q, pending_d;
    logic            prev_pending_q, prev_pending_d;
    logic [ID_W-1:0] image_q, image_d;
    logic            timer_wrap;

    always_comb begin
        timer_d    = timer_q;
        timer_wrap = 1'b0;
        if (run && !pause) begin
            if (timer_q == TIMER_LAST) begin
                timer_d    = '0;
                timer_wrap = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        image_d = image_q;
        if (frame_end) begin
            // Requests landing on the frame-end cycle are carried into the next frame.
            pending_d      = next_req | timer_wrap;
            prev_pending_d = prev_req;
            if (pending_q && !prev_pending_q) begin
                image_d = (image_q == IMG_LAST) ? '0 : image_q + 1'b1;
            end else if (!pending_q && prev_pending_q) begin
                image_d = (image_q == '0) ? IMG_LAST : image_q - 1'b1;
            end
        end else begin
            pending_d      = pending_q | next_req | timer_wrap;
            prev_pending_d = prev_pending_q | prev_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q        <= '0;
            pending_q      <= 1'b0;
            prev_pending_q <= 1'b0;
            image_q        <= '0;
        end else begin
            timer_q        <= timer_d;
            pending_q      <= pending_d;
            prev_pending_q <= prev_pending_d;
            image_q        <= image_d;
        end
    end

    assign image_id = image_q;

endmodule

// File: rtl/lcd_image_sequencer.sv
// Centres a 1bpp ROM image on the LCD and streams RGB332 pixel words to the SPI writer.
//   state   | meaning
//   IDLE    | waiting for LCD init to finish
//   FETCH   | decide area; present ROM address or pick border colour
//   WAIT    | ROM read latency countdown, then resolve fg/bg colour
//   PRESENT | pixel word held valid until the writer accepts it
module lcd_image_sequencer
    import lcd_pkg::*;
#(
    parameter int SCR_W         = 320,
    parameter int SCR_H         = 240,
    parameter int IMG_W         = 240,
    parameter int IMG_H         = 160,
    parameter int NUM_IMAGES    = 5,
    parameter int SWITCH_CYCLES = 12500000,
    parameter int ROM_LAT       = 1,
    parameter int ADDR_W        = 15
) (
    input  logic                                 clk_25MHz,
    input  logic                                 rst,
    input  logic                                 init_done,
    input  logic                                 pause,
    input  logic                                 next_req,
    input  logic                                 prev_req,
    input  logic [7:0]                           fg_color,
    input  logic [7:0]                           bg_color,
    input  logic [7:0]                           border_color,
    output logic [clog2_min1(NUM_IMAGES)-1:0]    rom_image_id,
    output logic [ADDR_W-1:0]                    rom_addr,
    input  logic [7:0]                           rom_data,
    output logic [8:0]                           pix_data,
    output logic                                 pix_valid,
    input  logic                                 pix_ready,
    output logic [clog2_min1(NUM_IMAGES)-1:0]    current_image_id,
    output logic                                 frame_start,
    output logic                                 display_active
);

    localparam int ID_W = clog2_min1(NUM_IMAGES);
    localparam int XW   = $clog2(SCR_W + 1);
    localparam int YW   = $clog2(SCR_H + 1);
    localparam int PW   = ADDR_W + 3;
    localparam int X0   = (SCR_W - IMG_W) / 2;
    localparam int Y0   = (SCR_H - IMG_H) / 2;

    localparam logic [XW-1:0] X_LO   = XW'(X0);
    localparam logic [XW-1:0] X_HI   = XW'(X0 + IMG_W);
    localparam logic [XW-1:0] X_LAST = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_LO   = YW'(Y0);
    localparam logic [YW-1:0] Y_HI   = YW'(Y0 + IMG_H);
    localparam logic [YW-1:0] Y_LAST = YW'(SCR_H - 1);
    localparam logic [1:0]    LAT    = 2'(ROM_LAT);

    seq_state_t      state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [PW-1:0]   pix_idx_q, pix_idx_d;
    logic [2:0]      bit_sel_q, bit_sel_d;
    logic [1:0]      wait_cnt_q, wait_cnt_d;
    logic [7:0]      colour_q, colour_d;
    logic            in_area;
    logic            frame_end;
    logic [ID_W-1:0] image_id;

    assign in_area = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        pix_idx_d  = pix_idx_q;
        bit_sel_d  = bit_sel_q;
        wait_cnt_d = wait_cnt_q;
        colour_d   = colour_q;
        frame_end  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (init_done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (in_area) begin
                    bit_sel_d  = ~pix_idx_q[2:0];
                    wait_cnt_d = LAT;
                    state_d    = ST_WAIT;
                end else begin
                    colour_d = border_color;
                    state_d  = ST_PRESENT;
                end
            end
            ST_WAIT: begin
                // rom_addr has been stable since FETCH, so the byte is valid on the last count.
                if (wait_cnt_q <= 2'd1) begin
                    colour_d = rom_data[bit_sel_q] ? fg_color : bg_color;
                    state_d  = ST_PRESENT;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_PRESENT: begin
                if (pix_ready) begin
                    state_d   = ST_FETCH;
                    frame_end = (x_q == X_LAST) && (y_q == Y_LAST);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (frame_end) begin
                        pix_idx_d = '0;
                    end else if (in_area) begin
                        pix_idx_d = pix_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            pix_idx_q  <= '0;
            bit_sel_q  <= '0;
            wait_cnt_q <= '0;
            colour_q   <= BLACK;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pix_idx_q  <= pix_idx_d;
            bit_sel_q  <= bit_sel_d;
            wait_cnt_q <= wait_cnt_d;
            colour_q   <= colour_d;
        end
    end

    lcd_image_switch_ctrl #(
        .NUM_IMAGES    (NUM_IMAGES),
        .SWITCH_CYCLES (SWITCH_CYCLES),
        .ID_W          (ID_W)
    ) u_switch_ctrl (
        .clk       (clk_25MHz),
        .rst       (rst),
        .run       (state_q != ST_IDLE),
        .pause     (pause),
        .next_req  (next_req),
        .prev_req  (prev_req),
        .frame_end (frame_end),
        .image_id  (image_id)
    );

    assign pix_valid        = (state_q == ST_PRESENT);
    assign pix_data         = {DC_DATA, colour_q};
    assign rom_addr         = pix_idx_q[PW-1:3];
    assign frame_start      = (state_q == ST_FETCH) && (x_q == '0) && (y_q == '0);
    assign display_active   = (state_q != ST_IDLE);
    assign rom_image_id     = image_id;
    assign current_image_id = image_id;

endmodule

// File: tb/tb_lcd_image_sequencer.sv
// Directed bench for lcd_image_sequencer on an 8x4 screen with a 4x2 image and a 1-cycle ROM.
module tb_lcd_image_sequencer;

    logic        clk_25MHz = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        pause = 1'b1;
    logic        next_req = 1'b0;
    logic        prev_req = 1'b0;
    logic        pix_ready = 1'b0;
    logic [7:0]  fg_color = 8'hFF;
    logic [7:0]  bg_color = 8'h00;
    logic [7:0]  border_color = 8'h1C;
    logic [7:0]  rom_data = 8'h00;
    logic [1:0]  rom_image_id;
    logic [1:0]  current_image_id;
    logic [14:0] rom_addr;
    logic [8:0]  pix_data;
    logic        pix_valid;
    logic        frame_start;
    logic        display_active;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_frame [32];
    logic [8:0] d;

    lcd_image_sequencer #(
        .SCR_W(8), .SCR_H(4), .IMG_W(4), .IMG_H(2),
        .NUM_IMAGES(3), .SWITCH_CYCLES(20), .ROM_LAT(1), .ADDR_W(15)
    ) dut (
        .clk_25MHz        (clk_25MHz),
        .rst              (rst),
        .init_done        (init_done),
        .pause            (pause),
        .next_req         (next_req),
        .prev_req         (prev_req),
        .fg_color         (fg_color),
        .bg_color         (bg_color),
        .border_color     (border_color),
        .rom_image_id     (rom_image_id),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .current_image_id (current_image_id),
        .frame_start      (frame_start),
        .display_active   (display_active)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk_25MHz) rom_data <= (rom_addr == 15'd0) ? 8'hA5 : 8'h00;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_pixel(output logic [8:0] data, input logic next_with_ready);
        int n = 0;
        while (pix_valid !== 1'b1 && n < 50) begin
            @(negedge clk_25MHz);
            n++;
        end
        check("pix_valid_wait", 16'(pix_valid), 16'd1);
        repeat (3) @(negedge clk_25MHz);
        check("pix_valid_hold", 16'(pix_valid), 16'd1);
        data = pix_data;
        pix_ready = 1'b1;
        next_req  = next_with_ready;
        @(negedge clk_25MHz);
        pix_ready = 1'b0;
        next_req  = 1'b0;
    endtask

    task automatic do_frame(input int next_at, input int prev_at, input int pause_at,
                            input logic next_end, input logic [1:0] img_mid,
                            input logic [1:0] img_end);
        logic [8:0] px;
        for (int i = 0; i < 32; i++) begin
            if (i == next_at) begin
                next_req = 1'b1;
                @(negedge clk_25MHz);
                next_req = 1'b0;
            end
            if (i == prev_at) begin
                prev_req = 1'b1;
                @(negedge clk_25MHz);
                prev_req = 1'b0;
            end
            if (i == pause_at) pause = 1'b1;
            if (i == 16) begin
                check("img_mid", 16'(current_image_id), 16'(img_mid));
                check("rom_addr_mid", 16'(rom_addr), 16'd0);
            end
            accept_pixel(px, next_end && (i == 31));
            check($sformatf("px%0d", i), 16'(px), 16'({1'b1, exp_frame[i]}));
        end
        check("img_end", 16'(current_image_id), 16'(img_end));
        check("rom_img_end", 16'(rom_image_id), 16'(img_end));
        check("frame_start_next", 16'(frame_start), 16'd1);
    endtask

    initial begin
        exp_frame = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C,
                      8'h1C, 8'h1C, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h1C, 8'h1C,
                      8'h1C, 8'h1C, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h1C, 8'h1C,
                      8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C};

        repeat (3) @(negedge clk_25MHz);
        check("rst_pix_valid", 16'(pix_valid), 16'd0);
        check("rst_pix_data", 16'(pix_data), 16'h100);
        check("rst_rom_addr", 16'(rom_addr), 16'd0);
        check("rst_frame_start", 16'(frame_start), 16'd0);
        check("rst_active", 16'(display_active), 16'd0);
        check("rst_image", 16'(current_image_id), 16'd0);
        rst = 1'b0;
        @(negedge clk_25MHz);
        check("idle_no_init", 16'(display_active), 16'd0);
        init_done = 1'b1;
        @(negedge clk_25MHz);
        check("first_frame_start", 16'(frame_start), 16'd1);
        check("first_fetch_valid", 16'(pix_valid), 16'd0);
        check("first_active", 16'(display_active), 16'd1);

        // Frame 1: paused, no requests.
        do_frame(-1, -1, -1, 1'b0, 2'd0, 2'd0);

        // Writer stalls; init_done dropping must not stop the stream.
        init_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_25MHz);
            check("stall_valid", 16'(pix_valid), 16'd1);
            check("stall_data", 16'(pix_data), 16'h11C);
        end

        do_frame(10, -1, -1, 1'b0, 2'd0, 2'd1);   // next mid-frame
        check("init_drop_active", 16'(display_active), 16'd1);
        do_frame(5, 20, -1, 1'b0, 2'd1, 2'd1);    // next + prev cancel
        do_frame(-1, 3, -1, 1'b0, 2'd1, 2'd0);    // prev
        do_frame(-1, 3, -1, 1'b0, 2'd0, 2'd2);    // prev wraps 0 -> 2
        do_frame(-1, -1, -1, 1'b1, 2'd2, 2'd2);   // next on frame-end cycle deferred
        do_frame(-1, -1, -1, 1'b0, 2'd2, 2'd0);   // deferred next applies, 2 -> 0

        // Auto-advance: frames are far longer than SWITCH_CYCLES.
        pause = 1'b0;
        do_frame(-1, -1, -1, 1'b0, 2'd0, 2'd1);
        do_frame(-1, -1, -1, 1'b0, 2'd1, 2'd2);
        do_frame(-1, -1, 28, 1'b0, 2'd2, 2'd0);
        do_frame(-1, 2, -1, 1'b0, 2'd0, 2'd2);

        // Partial frame, then reset while the first in-area pixel is in WAIT.
        for (int i = 0; i < 10; i++) begin
            accept_pixel(d, 1'b0);
            check($sformatf("pre_rst_px%0d", i), 16'(d), 16'({1'b1, exp_frame[i]}));
        end
        @(negedge clk_25MHz);
        check("wait_valid", 16'(pix_valid), 16'd0);
        check("wait_active", 16'(display_active), 16'd1);
        rst = 1'b1;
        @(negedge clk_25MHz);
        check("wrst_valid", 16'(pix_valid), 16'd0);
        check("wrst_active", 16'(display_active), 16'd0);
        check("wrst_image", 16'(current_image_id), 16'd0);
        check("wrst_data", 16'(pix_data), 16'h100);
        check("wrst_rom_addr", 16'(rom_addr), 16'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk_25MHz);
        check("post_rst_idle", 16'(display_active), 16'd0);
        init_done = 1'b1;
        @(negedge clk_25MHz);
        check("post_rst_frame_start", 16'(frame_start), 16'd1);
        check("post_rst_valid", 16'(pix_valid), 16'd0);
        accept_pixel(d, 1'b0);
        check("post_rst_px0", 16'(d), 16'h11C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
